// File: rtl/frame_sequencer.sv
// Per-instruction stage sequencer: walks fetch/decode/execute/memory/writeback stages,
// drives frame-field write enables from a per-field stage mask, and faults on stuck memory waits.
module frame_sequencer #(
    parameter int                        NUM_FIELDS  = 4,
    parameter logic [NUM_FIELDS*7-1:0]   STAGE_MAP   = {7'h02, 7'h30, 7'h08, 7'h04},
    parameter int                        MEM_TIMEOUT = 15,
    parameter int                        CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  halt_req,
    input  logic                  mem_ack,
    input  logic                  mem_valid,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic                  exec_stall,
    output logic [6:0]            state_onehot,
    output logic [NUM_FIELDS-1:0] field_we,
    output logic                  mem_req,
    output logic                  mem_is_data,
    output logic                  halted,
    output logic                  fault,
    output logic [CNT_W-1:0]      retired_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    // Stage bit positions, matching the STAGE_MAP field layout.
    localparam int B_FREQ   = 0;
    localparam int B_FRECV  = 1;
    localparam int B_DECODE = 2;
    localparam int B_SETUP  = 3;
    localparam int B_EXEC   = 4;
    localparam int B_MEMRD  = 5;
    localparam int B_WB     = 6;

    typedef enum logic [3:0] {
        S_IDLE, S_FREQ, S_FRECV, S_DECODE, S_SETUP,
        S_EXEC, S_MEMACC, S_WB, S_HALTED, S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic                ld_q, ld_d;
    logic                st_q, st_d;
    logic                acked_q, acked_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic [6:0]          stage_oh;
    logic [6:0]          stage_qual;
    logic                wait_expired;
    logic                mem_exit;

    // True when one more unsatisfied wait cycle reaches the timeout.
    assign wait_expired = (MEM_TIMEOUT != 0) && ((int'(wait_cnt_q) + 1) >= MEM_TIMEOUT);

    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        st_d        = st_q;
        acked_d     = acked_q;
        wait_cnt_d  = wait_cnt_q;
        retired_d   = retired_q;
        stage_oh    = '0;
        stage_qual  = '0;
        mem_req     = 1'b0;
        mem_is_data = 1'b0;
        mem_exit    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_FREQ;
                    wait_cnt_d = '0;
                end
            end
            S_FREQ: begin
                stage_oh[B_FREQ]   = 1'b1;
                stage_qual[B_FREQ] = mem_ack;
                mem_req            = 1'b1;
                if (mem_ack) begin
                    state_d    = S_FRECV;
                    wait_cnt_d = '0;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_FRECV: begin
                stage_oh[B_FRECV]   = 1'b1;
                stage_qual[B_FRECV] = mem_valid;
                if (mem_valid) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                stage_oh[B_DECODE]   = 1'b1;
                stage_qual[B_DECODE] = 1'b1;
                // A load+store encoding resolves to a load.
                ld_d    = is_load;
                st_d    = is_store & ~is_load;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                stage_oh[B_SETUP]   = 1'b1;
                stage_qual[B_SETUP] = 1'b1;
                state_d             = S_EXEC;
            end
            S_EXEC: begin
                stage_oh[B_EXEC]   = 1'b1;
                stage_qual[B_EXEC] = ~exec_stall;
                if (!exec_stall) begin
                    if (ld_q || st_q) begin
                        state_d    = S_MEMACC;
                        wait_cnt_d = '0;
                        acked_d    = 1'b0;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEMACC: begin
                stage_oh[B_MEMRD]   = 1'b1;
                stage_qual[B_MEMRD] = ld_q & mem_valid;
                mem_req             = ~acked_q;
                mem_is_data         = 1'b1;
                if (mem_ack) acked_d = 1'b1;
                // Stores complete on acceptance; loads wait for returned data.
                mem_exit = st_q ? mem_ack : mem_valid;
                if (mem_exit) begin
                    state_d = S_WB;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                stage_oh[B_WB]   = 1'b1;
                stage_qual[B_WB] = 1'b1;
                retired_d        = retired_q + 1'b1;
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_FREQ;
                    wait_cnt_d = '0;
                end
            end
            S_HALTED: begin
                if (!halt_req && run) begin
                    state_d    = S_FREQ;
                    wait_cnt_d = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            acked_q    <= 1'b0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
            acked_q    <= acked_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field_we
        assign field_we[gi] = |(STAGE_MAP[gi*7 +: 7] & stage_qual);
    end

    assign state_onehot  = stage_oh;
    assign halted        = (state_q == S_HALTED);
    assign fault         = (state_q == S_FAULT);
    assign retired_count = retired_q;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Multi-cycle instruction sequencer that owns the per-instruction stage state machine and drives the write enables for every frame register field.
- A per-field stage-mask parameter selects which stage writes each field; enables in wait stages are qualified by memory handshakes.
- Sits between the memory port and the frame registers; also provides memory-wait timeout fault, halt, and retired-instruction count.

Parameters:
- NUM_FIELDS, 4, number of frame fields with a write enable.
- STAGE_MAP, {7'h02,7'h30,7'h08,7'h04}, NUM_FIELDS×7 bits. Field i uses bits [7i+6:7i], ordered {wb,memread,exec,setup,decode,frecv,freq}. Default: f0=decode, f1=setup, f2=exec|memread, f3=frecv.
- MEM_TIMEOUT, 15, maximum cycles in any one memory wait stage; 0 disables the timeout.
- CNT_W, 32, width of the retired counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  leaves IDLE/HALTED when 1.
- halt_req  in  1  halt at the next instruction boundary.
- mem_ack  in  1  memory accepted mem_req.
- mem_valid  in  1  read data valid.
- is_load  in  1  decoded load; sampled in DECODE.
- is_store  in  1  decoded store; sampled in DECODE.
- exec_stall  in  1  holds EXECUTE.
- state_onehot  out  7  stage one-hot, same bit order as STAGE_MAP; 0 in IDLE/HALTED/FAULT.
- field_we  out  NUM_FIELDS  frame field write enables.
- mem_req  out  1  memory request.
- mem_is_data  out  1  1 = data access, 0 = instruction fetch.
- halted  out  1  1 in HALTED.
- fault  out  1  sticky timeout fault.
- retired_count  out  CNT_W  instructions completed.

Behaviour:
- States: IDLE, FREQ, FRECV, DECODE, SETUP, EXEC, MEMACC, WB, HALTED, FAULT. All registered.
- Reset: state=IDLE. state_onehot=0, field_we=0, mem_req=0, mem_is_data=0, halted=0, fault=0, retired_count=0.
- Reset mid-operation aborts the instruction immediately; no partial outputs survive.
- IDLE -> FREQ when run=1.
- FREQ:
  - mem_req=1, mem_is_data=0.
  - -> FRECV on mem_ack. Request held until mem_ack.
- FRECV:
  - -> DECODE on mem_valid.
  - Fields mapped to frecv assert field_we only in the mem_valid cycle.
  - mem_ack and mem_valid may both be seen within one instruction: FREQ takes ≥1 cycle, then FRECV takes ≥1 cycle.
- DECODE:
  - 1 cycle. Latches is_load and is_store.
  - Both asserted is treated as a load.
  - -> SETUP.
- SETUP: 1 cycle -> EXEC.
- EXEC:
  - Held while exec_stall=1. Exec-mapped field_we is suppressed during stalled cycles and asserts only in the final cycle.
  - Exit -> MEMACC if load|store, else -> WB.
- MEMACC:
  - mem_req=1, mem_is_data=1.
  - Load: mem_req stays high until mem_ack. Exits on mem_valid (same cycle as mem_ack allowed). Memread-mapped field_we asserts only in the mem_valid cycle.
  - Store: exits on mem_ack. Memread-mapped field_we stays 0.
  - -> WB.
- WB:
  - 1 cycle. retired_count += 1, wrapping at 2^CNT_W.
  - -> HALTED if halt_req=1, -> IDLE if run=0, else -> FREQ.
- field_we[i] = OR(STAGE_MAP field i & state_onehot), with the qualifications above. Combinational from registered state and inputs, same cycle.
- Stages without wait (decode/setup/wb) pulse exactly one cycle per instruction.
- HALTED: halted=1. -> FREQ when halt_req=0 and run=1.
- halt_req only takes effect in WB. An instruction in flight always completes.
- Timeout:
  - Wait counter clears on entering FREQ, FRECV and MEMACC.
  - Counts each cycle the exit condition is false.
  - On reaching MEM_TIMEOUT: -> FAULT, fault=1. Exit condition true in that same cycle wins; no fault.
- FAULT: mem_req=0, field_we=0. Left only by reset.

Test Plan:
- Default params, run=1, mem_ack and mem_valid each 1 cycle after request, ALU instruction -> state sequence FREQ,FRECV,DECODE,SETUP,EXEC,WB (8 cycles incl. waits); field_we pulses f3,f0,f1,f2 in order, one cycle each; retired_count=1.
- Load with mem_valid 3 cycles after MEMACC entry -> mem_req=1 with mem_is_data=1 until ack; f2 pulses once in EXEC and once in the mem_valid cycle; retired_count increments at WB.
- Store, then exec_stall=1 for 4 cycles on the next instruction -> store exits MEMACC on mem_ack with f2 low there; EXEC held 5 cycles with f2 high only in the last.
- MEM_TIMEOUT=15, mem_ack never asserted -> fault=1 on the 15th wait cycle; mem_req=0 and field_we=0 thereafter; only reset_n=0 clears it.
- halt_req=1 raised during SETUP -> instruction completes, WB -> HALTED, halted=1; drop halt_req -> FREQ next cycle.
- reset_n pulsed low asynchronously mid-MEMACC -> all outputs 0 immediately, state IDLE; with CNT_W=4, 16 instructions -> retired_count wraps to 0.
